iter_alu: RTL and testbench

Parametrised multi-cycle ALU, the next-generation execute unit for the RISC datapath. It keeps the single-cycle operations add, sub, shifts, NAND and OR. It adds iterative unsigned multiply and divide behind a start/busy/done handshake. Results and flags are registered, so the multicycle controller issues an operation, waits for `done`, then reads `result`/`result_hi`.

---
 rtl/iter_alu_if.sv | 29 ++
 rtl/iter_alu.sv | 163 ++++++++++++++++
 tb/tb_iter_alu.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/iter_alu_if.sv
// iter_alu_if: issue/completion bundle between a controller (master) and iter_alu (slave).
//   start, op, a, b : issue request and operands (master -> slave)
//   busy, done      : in-flight flag and one-cycle completion pulse (slave -> master)
//   result, result_hi, zf, dz, ill : registered results and flags (slave -> master)
interface iter_alu_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zf;
  logic             dz;
  logic             ill;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, zf, dz, ill
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, zf, dz, ill
  );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU. Single-cycle ADD/SUB/SLL/SRL/SRA/NAND/OR complete
// one edge after issue; MULU (shift-and-add) and DIVU (restoring) take WIDTH
// iteration edges. Results and flags are registered and held until the next
// completion.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : iter_alu_if slave modport (start/op/a/b in; busy/done/results/flags out)
module iter_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  iter_alu_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  // MULU: {partial product high, multiplier shifting out}.
  // DIVU: {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc, acc_d, iter;
  logic [WIDTH-1:0]   opb, opb_d;
  logic               is_div, is_div_d;
  logic               dz_pend, dz_pend_d;

  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zf_q, zf_d;
  logic               dz_q, dz_d;
  logic               ill_q, ill_d;

  logic [WIDTH-1:0]   alu_res;
  logic               reserved;
  logic               fits;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH:0]     sum;

  // Single-cycle datapath, fed directly from the issue operands.
  always_comb begin
    alu_res  = '0;
    reserved = 1'b0;
    case (bus.op)
      4'd0:    alu_res = bus.a + bus.b;
      4'd1:    alu_res = bus.a - bus.b;
      4'd2:    alu_res = bus.a << bus.b;
      4'd3:    alu_res = bus.a >> bus.b;
      4'd4:    alu_res = WIDTH'($signed(bus.a) >>> bus.b);
      4'd5:    alu_res = ~(bus.a & bus.b);
      4'd6:    alu_res = bus.a | bus.b;
      4'd8,
      4'd9:    alu_res = '0;
      default: reserved = 1'b1;
    endcase
  end

  // One multiply or divide iteration on the current accumulator.
  always_comb begin
    // The trial remainder {rem, next dividend bit} needs WIDTH+1 bits to
    // compare, but when it fits the difference is < 2^WIDTH, so only the low
    // WIDTH bits of the subtraction are kept.
    fits = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opb};
    diff = acc[2*WIDTH-2:WIDTH-1] - opb;
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    if (is_div) begin
      iter = fits ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      iter = {sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    acc_d     = acc;
    opb_d     = opb;
    is_div_d  = is_div;
    dz_pend_d = dz_pend;
    done_d    = 1'b0;
    res_d     = res_q;
    hi_d      = hi_q;
    zf_d      = zf_q;
    dz_d      = dz_q;
    ill_d     = ill_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == 4'd8 || bus.op == 4'd9) begin
            acc_d     = {{WIDTH{1'b0}}, bus.a};
            opb_d     = bus.b;
            is_div_d  = (bus.op == 4'd9);
            dz_pend_d = (bus.op == 4'd9) && (bus.b == '0);
            cnt_d     = CW'(WIDTH);
            state_d   = RUN;
          end else begin
            done_d = 1'b1;
            res_d  = alu_res;
            hi_d   = '0;
            zf_d   = (alu_res == '0);
            dz_d   = 1'b0;
            ill_d  = reserved;
          end
        end
      end
      RUN: begin
        acc_d = iter;
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = iter[WIDTH-1:0];
          hi_d    = iter[2*WIDTH-1:WIDTH];
          zf_d    = (iter[WIDTH-1:0] == '0);
          dz_d    = dz_pend;
          ill_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      dz_pend <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      zf_q    <= 1'b1;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      acc     <= acc_d;
      opb     <= opb_d;
      is_div  <= is_div_d;
      dz_pend <= dz_pend_d;
      done_q  <= done_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zf_q    <= zf_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.zf        = zf_q;
  assign bus.dz        = dz_q;
  assign bus.ill       = ill_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: scoreboard bench for iter_alu (WIDTH=16). Expected results are
// pushed when an op is issued and popped when done pulses.
module tb_iter_alu;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(W)) bus ();

  iter_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zf;
    logic         dz;
    logic         ill;
    int           exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [31:0] p;
    e.tag = ""; e.exp_cyc = 0;
    e.res = '0; e.hi = '0; e.dz = 1'b0; e.ill = 1'b0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = (b >= W) ? '0 : (a << b[3:0]);
      4'd3: e.res = (b >= W) ? '0 : (a >> b[3:0]);
      4'd4: e.res = (b >= W) ? {W{a[W-1]}} : W'($signed(a) >>> b[3:0]);
      4'd5: e.res = ~(a & b);
      4'd6: e.res = a | b;
      4'd8: begin
        p = {16'h0, a} * {16'h0, b};
        e.res = p[15:0];
        e.hi  = p[31:16];
      end
      4'd9: begin
        if (b == '0) begin
          e.res = '1; e.hi = a; e.dz = 1'b1;
        end else begin
          e.res = a / b; e.hi = a % b;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.zf = (e.res == '0);
    return e;
  endfunction

  exp_t got_e;
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check({got_e.tag, ".result"},    bus.result,    got_e.res);
        check({got_e.tag, ".result_hi"}, bus.result_hi, got_e.hi);
        check({got_e.tag, ".zf"},        bus.zf,        got_e.zf);
        check({got_e.tag, ".dz"},        bus.dz,        got_e.dz);
        check({got_e.tag, ".ill"},       bus.ill,       got_e.ill);
        check({got_e.tag, ".latency"},   cyc,           got_e.exp_cyc);
      end
    end
  end

  // Called at the negedge where start is driven; acceptance is at the next posedge.
  task automatic push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
    exp_t e;
    e = model(op, a, b);
    e.tag = tag;
    e.exp_cyc = cyc + ((op == 4'd8 || op == 4'd9) ? int'(W) + 1 : 1);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    push_exp(op, a, b, tag);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".completed"}, (sb.size() == 0), 32'd1);
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input string tag);
    issue(op, a, b, tag);
    wait_idle(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nb;
    int n;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.busy",      bus.busy,      32'd0);
    check("rst.done",      bus.done,      32'd0);
    check("rst.result",    bus.result,    32'd0);
    check("rst.result_hi", bus.result_hi, 32'd0);
    check("rst.zf",        bus.zf,        32'd1);
    check("rst.dz",        bus.dz,        32'd0);
    check("rst.ill",       bus.ill,       32'd0);
    rst = 1'b0;

    run(4'd0, 16'h8008, 16'h0003, "add");
    run(4'd1, 16'h8008, 16'h8008, "sub");
    run(4'd4, 16'h8008, 16'd3,    "sra");
    run(4'd4, 16'h8008, 16'd16,   "sra16");
    run(4'd3, 16'h8008, 16'd16,   "srl16");
    run(4'd2, 16'h8008, 16'd3,    "sll");
    run(4'd2, 16'h8008, 16'd40,   "sll40");
    run(4'd5, 16'hFFFF, 16'hFFFF, "nand");
    run(4'd6, 16'h1200, 16'h0034, "or");
    run(4'd7, 16'h1234, 16'h5678, "op7");
    run(4'd15, 16'h0001, 16'h0001, "op15");

    // MULU with a dropped ADD start pulsed while busy.
    issue(4'd8, 16'hFFFF, 16'hFFFF, "mulu");
    nb = 0;
    while (bus.busy && nb < 40) begin
      nb++;
      bus.start = (nb == 3); bus.op = 4'd0; bus.a = 16'd1; bus.b = 16'd1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("mulu.busy_cycles", nb, 32'd16);
    wait_idle("mulu");

    run(4'd9, 16'd100,  16'd7, "divu");
    run(4'd9, 16'h1234, 16'd0, "divu_dz");

    // Reset mid-RUN with a simultaneous start: both the MULU and the ADD vanish.
    issue(4'd8, 16'h1234, 16'h5678, "mulu_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 4'd0; bus.a = 16'd1; bus.b = 16'd1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    sb.delete();
    check("midrst.busy",      bus.busy,      32'd0);
    check("midrst.done",      bus.done,      32'd0);
    check("midrst.result",    bus.result,    32'd0);
    check("midrst.result_hi", bus.result_hi, 32'd0);
    check("midrst.zf",        bus.zf,        32'd1);
    check("midrst.dz",        bus.dz,        32'd0);
    repeat (20) @(negedge clk);
    run(4'd0, 16'd1, 16'd1, "add_after_rst");

    // Back-to-back: ADD issued in the DIVU done cycle.
    issue(4'd9, 16'd100, 16'd7, "divu_b2b");
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b.done_seen", bus.done, 32'd1);
    bus.start = 1'b1; bus.op = 4'd0; bus.a = 16'd2; bus.b = 16'd3;
    push_exp(4'd0, 16'd2, 16'd3, "add_b2b");
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("b2b");

    for (int i = 0; i < 16; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = (rop >= 4'd2 && rop <= 4'd4) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if (i == 5) rb = '0;
      run(rop, ra, rb, "rand");
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
